// File: rtl/proto245_cmd_pkg.sv
// rtl/proto245_cmd_pkg.sv - opcodes, parser state and decode helper for the RX command parser
package proto245_cmd_pkg;

    localparam int CMD_W = 32;

    localparam logic [CMD_W-1:0] CMD_TEST     = 32'hBADC0FFE;
    localparam logic [CMD_W-1:0] CMD_LED0_ON  = 32'h001711ED;
    localparam logic [CMD_W-1:0] CMD_LED0_OFF = 32'h00FF11ED;

    typedef enum logic {
        ST_IDLE,
        ST_ASSEMBLE
    } parser_state_e;

    typedef enum logic [1:0] {
        KIND_UNKNOWN,
        KIND_TEST,
        KIND_LED0_ON,
        KIND_LED0_OFF
    } cmd_kind_e;

    // Map a complete word onto the opcode it represents, if any
    function automatic cmd_kind_e decode_cmd(input logic [CMD_W-1:0] word);
        case (word)
            CMD_TEST:     decode_cmd = KIND_TEST;
            CMD_LED0_ON:  decode_cmd = KIND_LED0_ON;
            CMD_LED0_OFF: decode_cmd = KIND_LED0_OFF;
            default:      decode_cmd = KIND_UNKNOWN;
        endcase
    endfunction

endpackage

// File: rtl/rx_cmd_parser_if.sv
// rtl/rx_cmd_parser_if.sv - RX FIFO read port and command word valid/ready port
interface rx_cmd_parser_if;
    import proto245_cmd_pkg::*;

    logic             rxfifo_empty;
    logic             rxfifo_rd;
    logic [7:0]       rxfifo_data;
    logic             rxfifo_valid;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [CMD_W-1:0] cmd_word;

    // The parser drives the FIFO read strobe and the command word
    modport master (
        output rxfifo_rd, cmd_valid, cmd_word,
        input  rxfifo_empty, rxfifo_data, rxfifo_valid, cmd_ready
    );

    // The FIFO and the downstream consumer
    modport slave (
        input  rxfifo_rd, cmd_valid, cmd_word,
        output rxfifo_empty, rxfifo_data, rxfifo_valid, cmd_ready
    );

endinterface

// File: rtl/rx_cmd_parser.sv
// rtl/rx_cmd_parser.sv - assembles LSB-first 4-byte command words from the RX FIFO and decodes opcodes
module rx_cmd_parser
    import proto245_cmd_pkg::*;
#(
    parameter int BYTE_TIMEOUT = 50000,
    parameter int ERR_CNT_W    = 16
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst_n,
    rx_cmd_parser_if.master      bus,
    output logic                 cmd_test,
    output logic                 cmd_led0_on,
    output logic                 cmd_led0_off,
    output logic [ERR_CNT_W-1:0] unknown_cnt,
    output logic [ERR_CNT_W-1:0] timeout_cnt
);

    localparam int               TMR_W    = $clog2(BYTE_TIMEOUT);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(BYTE_TIMEOUT - 1);

    parser_state_e    r_state;
    parser_state_e    w_state_nxt;
    logic [1:0]       r_byte_cnt;
    logic [CMD_W-1:0] r_shreg;
    logic [CMD_W-1:0] w_shreg_nxt;
    logic [TMR_W-1:0] r_timer;
    logic             r_cmd_valid;
    logic [CMD_W-1:0] r_cmd_word;
    logic             w_complete;
    logic             w_timeout;
    cmd_kind_e        w_kind;

    // Reads pause only while a finished word is stuck waiting for the consumer
    assign bus.rxfifo_rd = sys_rst_n & ~bus.rxfifo_empty & (~r_cmd_valid | bus.cmd_ready);
    assign bus.cmd_valid = r_cmd_valid;
    assign bus.cmd_word  = r_cmd_word;
    assign w_kind        = decode_cmd(w_shreg_nxt);

    // Next state, word-complete and timeout detection; an arriving byte always beats the timeout
    always_comb begin
        w_state_nxt = r_state;
        w_complete  = 1'b0;
        w_timeout   = 1'b0;
        w_shreg_nxt = {bus.rxfifo_data, r_shreg[CMD_W-1:8]};
        case (r_state)
            ST_IDLE: begin
                if (bus.rxfifo_valid) begin
                    w_state_nxt = ST_ASSEMBLE;
                end
            end
            ST_ASSEMBLE: begin
                if (bus.rxfifo_valid) begin
                    if (r_byte_cnt == 2'd3) begin
                        w_complete  = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end
                end else if (r_timer == TMR_LAST) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Byte assembly and inter-byte timer; the shift register is independent of the held cmd_word
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_shreg    <= '0;
            r_byte_cnt <= '0;
            r_timer    <= '0;
        end else begin
            if (bus.rxfifo_valid) begin
                r_shreg    <= w_shreg_nxt;
                r_byte_cnt <= r_byte_cnt + 2'd1;
            end else if (w_timeout) begin
                r_shreg    <= '0;
                r_byte_cnt <= '0;
            end
            if (bus.rxfifo_valid || w_timeout || (r_state == ST_IDLE)) begin
                r_timer <= '0;
            end else begin
                r_timer <= r_timer + TMR_W'(1);
            end
        end
    end

    // Word hand-off, decode pulses and saturating error counters
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_cmd_valid  <= 1'b0;
            r_cmd_word   <= '0;
            cmd_test     <= 1'b0;
            cmd_led0_on  <= 1'b0;
            cmd_led0_off <= 1'b0;
            unknown_cnt  <= '0;
            timeout_cnt  <= '0;
        end else begin
            cmd_test     <= 1'b0;
            cmd_led0_on  <= 1'b0;
            cmd_led0_off <= 1'b0;
            // A compliant FIFO cannot complete a word while one is held, so completion always loads
            if (w_complete) begin
                r_cmd_valid  <= 1'b1;
                r_cmd_word   <= w_shreg_nxt;
                cmd_test     <= (w_kind == KIND_TEST);
                cmd_led0_on  <= (w_kind == KIND_LED0_ON);
                cmd_led0_off <= (w_kind == KIND_LED0_OFF);
                if ((w_kind == KIND_UNKNOWN) && !(&unknown_cnt)) begin
                    unknown_cnt <= unknown_cnt + ERR_CNT_W'(1);
                end
            end else if (r_cmd_valid && bus.cmd_ready) begin
                r_cmd_valid <= 1'b0;
            end
            if (w_timeout && !(&timeout_cnt)) begin
                timeout_cnt <= timeout_cnt + ERR_CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_rx_cmd_parser.sv
// tb/tb_rx_cmd_parser.sv - directed self-checking bench for rx_cmd_parser
module tb_rx_cmd_parser;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cmd_test, cmd_led0_on, cmd_led0_off;
    logic [1:0] unknown_cnt, timeout_cnt;

    rx_cmd_parser_if bus();

    rx_cmd_parser #(.BYTE_TIMEOUT(16), .ERR_CNT_W(2)) dut (
        .sys_clk      (clk),
        .sys_rst_n    (rst_n),
        .bus          (bus),
        .cmd_test     (cmd_test),
        .cmd_led0_on  (cmd_led0_on),
        .cmd_led0_off (cmd_led0_off),
        .unknown_cnt  (unknown_cnt),
        .timeout_cnt  (timeout_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // FIFO model: byte array with read data one cycle after an accepted read
    logic [7:0] mem [0:255];
    int wr_ptr = 0;
    int rd_ptr = 0;
    assign bus.rxfifo_empty = (wr_ptr == rd_ptr);

    initial begin
        bus.rxfifo_valid = 1'b0;
        bus.rxfifo_data  = 8'h00;
        bus.cmd_ready    = 1'b1;
    end

    always @(posedge clk) begin
        bus.rxfifo_valid <= 1'b0;
        if (bus.rxfifo_rd) begin
            bus.rxfifo_data  <= mem[rd_ptr[7:0]];
            bus.rxfifo_valid <= 1'b1;
            rd_ptr           <= rd_ptr + 1;
        end
    end

    // Monitor: accepted words, pulse counts, timing marks and cmd_word stability
    logic [31:0] acc_q[$];
    int cyc = 0, last_valid_cyc = 0, rise_cyc = 0, test_cyc = 0;
    int n_test = 0, n_on = 0, n_off = 0, stab_err = 0;
    logic        prev_v = 1'b0, prev_r = 1'b0;
    logic [31:0] prev_w = '0;

    always @(negedge clk) begin
        cyc++;
        if (bus.rxfifo_valid) last_valid_cyc = cyc;
        if (bus.cmd_valid && !prev_v) rise_cyc = cyc;
        if (cmd_test) begin n_test++; test_cyc = cyc; end
        if (cmd_led0_on) n_on++;
        if (cmd_led0_off) n_off++;
        if (prev_v && !prev_r && bus.cmd_valid && (bus.cmd_word != prev_w)) stab_err++;
        if (bus.cmd_valid && bus.cmd_ready) acc_q.push_back(bus.cmd_word);
        prev_v = bus.cmd_valid;
        prev_r = bus.cmd_ready;
        prev_w = bus.cmd_word;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic push(input logic [7:0] b);
        mem[wr_ptr[7:0]] = b;
        wr_ptr++;
    endtask

    task automatic push_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) push(w[8*i +: 8]);
    endtask

    task automatic wait_acc(input int n, input int budget);
        int k = 0;
        while (acc_q.size() < n && k < budget) begin
            @(posedge clk);
            k++;
        end
        #1;
        chk("acc_count", 32'(acc_q.size()), 32'(n));
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        tick(3);
        chk("rst_valid", 32'(bus.cmd_valid), 32'd0);
        chk("rst_word", bus.cmd_word, 32'd0);
        chk("rst_cnts", {28'd0, unknown_cnt, timeout_cnt}, 32'd0);
        rst_n = 1'b1;
        tick(2);

        // 1: CMD_TEST with ready tied high, one-cycle latency
        push_word(32'hBADC0FFE);
        wait_acc(1, 50);
        tick(2);
        chk("t1_word", acc_q[0], 32'hBADC0FFE);
        chk("t1_pulses", {8'(n_test), 8'(n_on), 8'(n_off)}, {8'd1, 8'd0, 8'd0});
        chk("t1_latency", 32'(rise_cyc - last_valid_cyc), 32'd1);
        chk("t1_pulse_cyc", 32'(test_cyc - rise_cyc), 32'd0);
        chk("t1_cnts", {28'd0, unknown_cnt, timeout_cnt}, 32'd0);

        // 2: LED0 on then off
        push_word(32'h001711ED);
        push_word(32'h00FF11ED);
        wait_acc(3, 60);
        tick(2);
        chk("t2_word_on", acc_q[1], 32'h001711ED);
        chk("t2_word_off", acc_q[2], 32'h00FF11ED);
        chk("t2_pulses", {8'(n_test), 8'(n_on), 8'(n_off)}, {8'd1, 8'd1, 8'd1});

        // 3: unknown word
        push(8'h11); push(8'h22); push(8'h33); push(8'h44);
        wait_acc(4, 50);
        tick(2);
        chk("t3_word", acc_q[3], 32'h44332211);
        chk("t3_unknown", 32'(unknown_cnt), 32'd1);
        chk("t3_pulses", {8'(n_test), 8'(n_on), 8'(n_off)}, {8'd1, 8'd1, 8'd1});

        // 4: stale partial frame dropped after the inter-byte timeout
        push(8'hFE); push(8'h0F);
        tick(24);
        chk("t4_timeout", 32'(timeout_cnt), 32'd1);
        chk("t4_no_word", 32'(bus.cmd_valid), 32'd0);
        push_word(32'hBADC0FFE);
        wait_acc(5, 50);
        tick(10);
        chk("t4_word", acc_q[4], 32'hBADC0FFE);
        chk("t4_no_spurious", 32'(acc_q.size()), 32'd5);
        chk("t4_test_cnt", 32'(n_test), 32'd2);

        // 5: backpressure stalls reads after the first word plus one in-flight byte
        bus.cmd_ready = 1'b0;
        for (int i = 0; i < 3; i++) push_word(32'hBADC0FFE);
        tick(10);
        chk("t5_fifo_left", 32'(wr_ptr - rd_ptr), 32'd7);
        chk("t5_held_valid", 32'(bus.cmd_valid), 32'd1);
        chk("t5_held_word", bus.cmd_word, 32'hBADC0FFE);
        chk("t5_acc_stalled", 32'(acc_q.size()), 32'd5);
        bus.cmd_ready = 1'b1;
        wait_acc(8, 100);
        tick(2);
        for (int i = 5; i < 8; i++) chk("t5_word", acc_q[i], 32'hBADC0FFE);
        chk("t5_test_cnt", 32'(n_test), 32'd5);
        chk("t5_stable", 32'(stab_err), 32'd0);
        chk("t5_fifo_empty", 32'(wr_ptr - rd_ptr), 32'd0);

        // Unknown counter saturates at all-ones (2-bit counter: 4 unknown words -> 3)
        for (int i = 0; i < 3; i++) push_word(32'h44332211);
        wait_acc(11, 150);
        tick(2);
        chk("sat_unknown", 32'(unknown_cnt), 32'd3);
        chk("sat_timeout", 32'(timeout_cnt), 32'd1);

        // 6: reset mid-frame clears everything, then a clean frame decodes once
        push(8'hFE); push(8'h0F);
        tick(4);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_rst_valid", 32'(bus.cmd_valid), 32'd0);
        chk("t6_rst_word", bus.cmd_word, 32'd0);
        chk("t6_rst_cnts", {28'd0, unknown_cnt, timeout_cnt}, 32'd0);
        chk("t6_rst_rd", 32'(bus.rxfifo_rd), 32'd0);
        tick(3);
        rst_n = 1'b1;
        tick(2);
        push_word(32'hBADC0FFE);
        wait_acc(12, 50);
        tick(10);
        chk("t6_word", acc_q[11], 32'hBADC0FFE);
        chk("t6_acc_total", 32'(acc_q.size()), 32'd12);
        chk("t6_pulses", {8'(n_test), 8'(n_on), 8'(n_off)}, {8'd6, 8'd1, 8'd1});
        chk("t6_cnts", {28'd0, unknown_cnt, timeout_cnt}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
